// File: rtl/fc_act_stream.sv
`default_nettype none
// ============================================================================
// Module   : fc_act_stream
// Purpose  : FC-layer output stage. Reads the CIM output buffers one output
//            neuron at a time and adds the partial sums of all vertical tiles.
//            It then applies the activation, requantises with an arithmetic
//            right shift, saturates the result and streams it into the next
//            layer's input buffer.
// Options  : FC_ACT_RELU_EN  - define for ReLU with an unsigned output.
//            Leave it undefined for identity with a two's-complement output.
// Revision : 1.0  initial release
// ============================================================================
module fc_act_stream #(
    parameter int OUTPUT_NEURONS = 10,
    parameter int XBAR_SIZE      = 512,
    parameter int DATA_SIZE      = 8,
    parameter int V_CIM_TILES    = 2,
    parameter int H_CIM_TILES    = 1,
    parameter int OBUF_DATA_SIZE = 2*DATA_SIZE + $clog2(XBAR_SIZE),
    parameter int SHIFT          = 4,
    localparam int C_ELEMS       = XBAR_SIZE / DATA_SIZE,
    localparam int C_ADDR_W      = (C_ELEMS > 1) ? $clog2(C_ELEMS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_start,
    input  logic                      i_cim_ready,
    output logic                      o_ready,
    output logic [C_ADDR_W-1:0]       o_cim_rd_addr,
    input  logic [V_CIM_TILES-1:0][H_CIM_TILES-1:0][OBUF_DATA_SIZE-1:0] i_data,
    input  logic                      i_next_ready,
    output logic                      o_we,
    output logic [DATA_SIZE-1:0]      o_data,
    output logic                      o_done
);

    // Accumulator has enough headroom for the tile sum plus the sign bit.
    localparam int C_ACC_W = OBUF_DATA_SIZE + $clog2(V_CIM_TILES) + 1;
    localparam int C_H_W   = (H_CIM_TILES > 1) ? $clog2(H_CIM_TILES) : 1;
    localparam int C_N_W   = (OUTPUT_NEURONS > 1) ? $clog2(OUTPUT_NEURONS) : 1;

    localparam logic [2:0] C_ST_IDLE = 3'd0;
    localparam logic [2:0] C_ST_WAIT = 3'd1;
    localparam logic [2:0] C_ST_SUM  = 3'd2;
    localparam logic [2:0] C_ST_OUT  = 3'd3;
    localparam logic [2:0] C_ST_DONE = 3'd4;

    logic [2:0]                  r_state_q, w_state_d;
    logic [C_N_W-1:0]            r_n_q,     w_n_d;
    logic [C_ADDR_W-1:0]         r_col_q,   w_col_d;
    logic [C_H_W-1:0]            r_h_q,     w_h_d;
    logic [DATA_SIZE-1:0]        r_data_q,  w_data_d;

    logic signed [C_ACC_W-1:0]   w_acc;
    logic signed [C_ACC_W-1:0]   w_shift;
    logic [DATA_SIZE-1:0]        w_sat;
    logic                        w_last;
    logic                        w_accept;
    logic                        w_hs;

    assign w_last   = (r_n_q == C_N_W'(OUTPUT_NEURONS - 1));
    assign w_accept = i_start & i_cim_ready;
    assign w_hs     = (r_state_q == C_ST_OUT) & i_next_ready;

    // State and datapath registers; reset aborts any pass in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state_q <= C_ST_IDLE;
            r_n_q     <= '0;
            r_col_q   <= '0;
            r_h_q     <= '0;
            r_data_q  <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_n_q     <= w_n_d;
            r_col_q   <= w_col_d;
            r_h_q     <= w_h_d;
            r_data_q  <= w_data_d;
        end
    end

    // Next-state logic for the read/sum/output sequence.
    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            C_ST_IDLE: if (w_accept) w_state_d = C_ST_WAIT;
            C_ST_WAIT: w_state_d = C_ST_SUM;
            C_ST_SUM:  w_state_d = C_ST_OUT;
            C_ST_OUT:  if (i_next_ready) w_state_d = w_last ? C_ST_DONE : C_ST_WAIT;
            C_ST_DONE: w_state_d = C_ST_IDLE;
            default:   w_state_d = C_ST_IDLE;
        endcase
    end

    // Sum the partial results of every vertical tile for the current column.
    always_comb begin
        w_acc = '0;
        for (int v = 0; v < V_CIM_TILES; v++) begin
            w_acc = w_acc + {{(C_ACC_W-OBUF_DATA_SIZE){i_data[v][r_h_q][OBUF_DATA_SIZE-1]}},
                             i_data[v][r_h_q]};
        end
        w_shift = w_acc >>> SHIFT;
    end

`ifdef FC_ACT_RELU_EN
    localparam logic signed [C_ACC_W-1:0] C_SAT_HI = C_ACC_W'((1 << DATA_SIZE) - 1);

    // ReLU, then clamp to the unsigned output range.
    always_comb begin
        if (w_shift < 0)
            w_sat = '0;
        else if (w_shift > C_SAT_HI)
            w_sat = {DATA_SIZE{1'b1}};
        else
            w_sat = w_shift[DATA_SIZE-1:0];
    end
`else
    localparam logic signed [C_ACC_W-1:0] C_SAT_HI = C_ACC_W'((1 << (DATA_SIZE-1)) - 1);
    localparam logic signed [C_ACC_W-1:0] C_SAT_LO = C_ACC_W'(-(1 << (DATA_SIZE-1)));

    // Identity activation, clamp to the two's-complement output range.
    always_comb begin
        if (w_shift > C_SAT_HI)
            w_sat = {1'b0, {(DATA_SIZE-1){1'b1}}};
        else if (w_shift < C_SAT_LO)
            w_sat = {1'b1, {(DATA_SIZE-1){1'b0}}};
        else
            w_sat = w_shift[DATA_SIZE-1:0];
    end
`endif

    // Counter and output-data updates: clear on start, latch in SUM, advance on handshake.
    always_comb begin
        w_n_d    = r_n_q;
        w_col_d  = r_col_q;
        w_h_d    = r_h_q;
        w_data_d = r_data_q;
        if ((r_state_q == C_ST_IDLE) && w_accept) begin
            w_n_d   = '0;
            w_col_d = '0;
            w_h_d   = '0;
        end
        if (r_state_q == C_ST_SUM) begin
            w_data_d = w_sat;
        end
        if (w_hs && !w_last) begin
            w_n_d = r_n_q + C_N_W'(1);
            if (r_col_q == C_ADDR_W'(C_ELEMS - 1)) begin
                w_col_d = '0;
                w_h_d   = r_h_q + C_H_W'(1);
            end else begin
                w_col_d = r_col_q + C_ADDR_W'(1);
            end
        end
    end

    // State-decoded outputs; the write strobe follows downstream readiness in OUT.
    always_comb begin
        o_ready = (r_state_q == C_ST_IDLE);
        o_we    = w_hs;
        o_done  = (r_state_q == C_ST_DONE);
    end

    assign o_data        = r_data_q;
    assign o_cim_rd_addr = r_col_q;

endmodule
`default_nettype wire

// File: tb/tb_fc_act_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_fc_act_stream
// Purpose  : Scoreboard testbench for fc_act_stream (4 neurons, 2 elements
//            per H tile, 2 H tiles, 2 V tiles).
// Revision : 1.0  initial release
// ============================================================================
module tb_fc_act_stream;

    localparam int DW = 8;
    localparam int OW = 20;   // 2*8 + clog2(16)

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic i_start = 1'b0;
    logic i_cim_ready = 1'b0;
    logic i_next_ready = 1'b0;
    logic o_ready, o_we, o_done;
    logic [0:0]    o_cim_rd_addr;
    logic [DW-1:0] o_data;
    logic [1:0][1:0][OW-1:0] i_data = '0;

    logic signed [OW-1:0] obuf [2][2][2];   // [v][h][col]
    logic [DW-1:0] exp_data [4];

    typedef struct packed {
        logic [DW-1:0] data;
        logic [0:0]    col;
        logic          last;
    } exp_t;
    exp_t q [$];

    int  n_cmp = 0;
    int  n_err = 0;
    bit  exp_done = 1'b0;

    fc_act_stream #(
        .OUTPUT_NEURONS(4),
        .XBAR_SIZE     (16),
        .H_CIM_TILES   (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .i_cim_ready  (i_cim_ready),
        .o_ready      (o_ready),
        .o_cim_rd_addr(o_cim_rd_addr),
        .i_data       (i_data),
        .i_next_ready (i_next_ready),
        .o_we         (o_we),
        .o_data       (o_data),
        .o_done       (o_done)
    );

    always #5 clk = ~clk;

    // Output-buffer model with one cycle of read latency.
    always @(posedge clk) begin
        for (int v = 0; v < 2; v++)
            for (int h = 0; h < 2; h++)
                i_data[v][h] <= obuf[v][h][o_cim_rd_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pop the scoreboard on each write, check o_done after the last one.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            exp_done = 1'b0;
        end else begin
            if (exp_done) begin
                chk("mon_done", 32'(o_done), 32'd1);
                exp_done = 1'b0;
            end else if (o_done) begin
                n_cmp++;
                n_err++;
                $display("FAIL mon_done: got unexpected o_done=1 expected 0");
            end
            if (o_we) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL mon_we: got unexpected o_we data=%0h expected no write", o_data);
                end else begin
                    e = q.pop_front();
                    chk("mon_data", 32'(o_data), 32'(e.data));
                    chk("mon_addr", 32'(o_cim_rd_addr), 32'(e.col));
                    if (e.last) exp_done = 1'b1;
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_pass(input int count, input bit mark_last);
        exp_t e;
        for (int i = 0; i < count; i++) begin
            e.data = exp_data[i];
            e.col  = 1'(i % 2);
            e.last = mark_last && (i == count - 1);
            q.push_back(e);
        end
    endtask

    task automatic start_pass;
        i_start     = 1'b1;
        i_cim_ready = 1'b1;
        tick();
        i_start     = 1'b0;
    endtask

    task automatic wait_done;
        bit seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (o_done) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk("done_seen", 32'(seen), 32'd1);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ready"}, 32'(o_ready),       32'd1);
        chk({tag, "_we"},    32'(o_we),          32'd0);
        chk({tag, "_done"},  32'(o_done),        32'd0);
        chk({tag, "_data"},  32'(o_data),        32'd0);
        chk({tag, "_addr"},  32'(o_cim_rd_addr), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish within 100000");
        $fatal(1, "timeout");
    end

    initial begin
        // col0/h0: 100+60 -> 10; col1/h0: 8000 -> saturates;
        // col0/h1: -50 -> floor(-3.125) = -4; col1/h1: -8000 -> saturates low.
        obuf[0][0][0] = 20'sd100;   obuf[1][0][0] = 20'sd60;
        obuf[0][0][1] = 20'sd5000;  obuf[1][0][1] = 20'sd3000;
        obuf[0][1][0] = -20'sd20;   obuf[1][1][0] = -20'sd30;
        obuf[0][1][1] = -20'sd5000; obuf[1][1][1] = -20'sd3000;
`ifdef FC_ACT_RELU_EN
        exp_data[0] = 8'd10; exp_data[1] = 8'd255; exp_data[2] = 8'h00; exp_data[3] = 8'h00;
`else
        exp_data[0] = 8'd10; exp_data[1] = 8'd127; exp_data[2] = 8'hFC; exp_data[3] = 8'h80;
`endif

        // Reset state.
        repeat (3) tick();
        chk_reset_state("rst0");
        rst = 1'b1;
        tick();

        // Start without CIM ready is ignored.
        i_start = 1'b1;
        i_cim_ready = 1'b0;
        repeat (3) begin
            tick();
            chk("idle_no_cim_ready", 32'(o_ready), 32'd1);
        end
        i_start = 1'b0;

        // Pass 1: full pass, no backpressure, latency check.
        i_next_ready = 1'b1;
        push_pass(4, 1'b1);
        start_pass();
        chk("lat_k_ready", 32'(o_ready), 32'd0);
        chk("lat_k_we",    32'(o_we),    32'd0);
        tick();
        chk("lat_k1_we",   32'(o_we),    32'd0);
        tick();
        chk("lat_k2_we",   32'(o_we),    32'd1);
        wait_done();
        tick();
        chk("p1_idle_ready", 32'(o_ready), 32'd1);

        // Pass 2: hold the first element with backpressure, stray start mid-pass.
        i_next_ready = 1'b0;
        push_pass(4, 1'b1);
        start_pass();
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_we",   32'(o_we),          32'd0);
            chk("bp_data", 32'(o_data),        32'(exp_data[0]));
            chk("bp_addr", 32'(o_cim_rd_addr), 32'd0);
            i_start = (i == 2);
            tick();
        end
        i_start = 1'b0;
        i_next_ready = 1'b1;
        wait_done();
        repeat (5) tick();
        chk("p2_idle_ready", 32'(o_ready), 32'd1);

        // Pass 3: reset while the second element waits in OUT.
        push_pass(1, 1'b0);
        start_pass();
        tick();
        tick();
        tick();
        i_next_ready = 1'b0;
        tick();
        tick();
        chk("p3_out_data", 32'(o_data),        32'(exp_data[1]));
        chk("p3_out_addr", 32'(o_cim_rd_addr), 32'd1);
        chk("p3_out_ready", 32'(o_ready),      32'd0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        i_next_ready = 1'b1;
        chk_reset_state("rst1");
        repeat (8) tick();
        chk("p3_idle_ready", 32'(o_ready), 32'd1);
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
